// File: rtl/conv_mem_host.sv
// -----------------------------------------------------------------------------
// conv_mem_host
//
// Host-side responder for the convolution engine's memory interface. Holds the
// input image ROM and five layer banks, answers the engine's image/layer reads,
// captures its layer writes, runs the ready->busy handshake and reports
// completion, watchdog timeouts and bank-select errors. The host fills the
// image through the load port and reads anything back through the dump port.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   start                  host pulse: launch one engine run (IDLE only)
//   load_en/addr/data      host image write (IDLE only)
//   dump_sel/addr/data     host readback, combinational (000 = image)
//   ready / busy           handshake to / from the engine
//   iaddr / idata          engine image read, combinational
//   cwr/caddr_wr/cdata_wr  engine layer write
//   crd/caddr_rd/cdata_rd  engine layer read, combinational
//   csel                   layer bank select, 001..101 valid
//   done                   one-cycle pulse at end of run
//   timeout                sticky: last run aborted by the watchdog
//   sel_err                sticky: layer access with invalid csel
//   wr_cnt                 accepted layer writes since the last start
// -----------------------------------------------------------------------------
module conv_mem_host #(
    parameter int          AW      = 12,
    parameter int          DW      = 20,
    parameter logic [31:0] TIMEOUT = 32'd2000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic [2:0]    dump_sel,
    input  logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    output logic          done,
    output logic          timeout,
    output logic          sel_err,
    output logic [AW:0]   wr_cnt
);

    localparam int          DEPTH   = 1 << AW;
    // Abort on the edge that closes the TIMEOUT-th cycle spent in ARM+RUN.
    localparam logic [31:0] WD_LAST = TIMEOUT - 32'd1;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t        state;
    logic [31:0]   wd_cnt;

    logic [DW-1:0] image_mem [DEPTH];
    logic [DW-1:0] bank_mem  [5][DEPTH];

    function automatic logic sel_valid(input logic [2:0] sel);
        return (sel >= 3'd1) && (sel <= 3'd5);
    endfunction

    // csel 001..101 maps onto bank_mem[0..4].
    logic [2:0] csel_bank;
    logic [2:0] dump_bank;
    logic       wr_ok;
    logic       rd_ok;
    logic       err_now;
    logic       run_clear;

    assign csel_bank = csel - 3'd1;
    assign dump_bank = dump_sel - 3'd1;
    assign wr_ok     = cwr && sel_valid(csel);
    assign rd_ok     = crd && sel_valid(csel);
    assign err_now   = (cwr || crd) && !sel_valid(csel);
    assign run_clear = (state == IDLE) && start;

    // ------------------------------------------------------------------
    // Control FSM, watchdog and status flags
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wd_cnt  <= '0;
            ready   <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            sel_err <= 1'b0;
            wr_cnt  <= '0;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ARM;
                        ready   <= 1'b1;
                        wd_cnt  <= '0;
                        timeout <= 1'b0;
                    end
                end
                ARM, RUN: begin
                    // Watchdog has priority over the engine's handshake.
                    if (wd_cnt == WD_LAST) begin
                        state   <= DONE;
                        ready   <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                        if (state == ARM && busy) begin
                            state <= RUN;
                            ready <= 1'b0;
                        end else if (state == RUN && !busy) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // A start clears the run statistics; an access in the same cycle
            // already belongs to the new run.
            if (run_clear) begin
                sel_err <= err_now;
                wr_cnt  <= {{AW{1'b0}}, wr_ok};
            end else begin
                if (err_now) sel_err <= 1'b1;
                if (wr_ok && (wr_cnt != '1)) wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage writes
    // ------------------------------------------------------------------
    // NOTE: the arrays are deliberately outside the reset domain: contents
    // survive a reset and the block maps onto plain RAM without a clear path.
    always_ff @(posedge clk) begin
        if (state == IDLE && load_en) image_mem[load_addr] <= load_data;
        if (wr_ok) bank_mem[csel_bank][caddr_wr] <= cdata_wr;
    end

    // ------------------------------------------------------------------
    // Combinational reads (a same-cycle write lands at the edge, so the
    // read returns the old word this cycle)
    // ------------------------------------------------------------------
    assign idata = image_mem[iaddr];

    // NOTE: each always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        cdata_rd = '0;
        if (rd_ok) cdata_rd = bank_mem[csel_bank][caddr_rd];
    end

    always_comb begin
        dump_data = '0;
        if (dump_sel == 3'd0)        dump_data = image_mem[dump_addr];
        else if (sel_valid(dump_sel)) dump_data = bank_mem[dump_bank][dump_addr];
    end

endmodule

// File: tb/tb_conv_mem_host.sv
// -----------------------------------------------------------------------------
// tb_conv_mem_host
//
// Self-checking bench for conv_mem_host. Two instances share every input: one
// with the default watchdog and one with TIMEOUT=50 for the abort scenario.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or just after a falling-edge input change for combinational reads.
// -----------------------------------------------------------------------------
module tb_conv_mem_host;

    localparam int AW       = 12;
    localparam int DW       = 20;
    localparam int DEPTH    = 1 << AW;
    localparam int TO_SMALL = 50;
    localparam int BUSY_DLY = 3;
    localparam int RUN_LEN  = 100;

    logic          clk;
    logic          reset;
    logic          start;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic [2:0]    dump_sel;
    logic [AW-1:0] dump_addr;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [2:0]    csel;

    logic [DW-1:0] dump_data, idata, cdata_rd;
    logic          ready, done, timeout, sel_err;
    logic [AW:0]   wr_cnt;

    logic [DW-1:0] t_dump_data, t_idata, t_cdata_rd;
    logic          t_ready, t_done, t_timeout, t_sel_err;
    logic [AW:0]   t_wr_cnt;

    conv_mem_host #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data),
        .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .done(done), .timeout(timeout), .sel_err(sel_err), .wr_cnt(wr_cnt)
    );

    conv_mem_host #(.AW(AW), .DW(DW), .TIMEOUT(32'd50)) dut_to (
        .clk(clk), .reset(reset), .start(start),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(t_dump_data),
        .ready(t_ready), .busy(busy), .iaddr(iaddr), .idata(t_idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(t_cdata_rd), .csel(csel),
        .done(t_done), .timeout(t_timeout), .sel_err(t_sel_err), .wr_cnt(t_wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_cmp = 0;
    int            n_err = 0;
    int            exp_wr_cnt = 0;
    int            busy_rise_cyc = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_w;

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; start = 0; load_en = 0; load_addr = '0; load_data = '0;
        dump_sel = '0; dump_addr = '0; busy = 0; iaddr = '0; cwr = 0;
        caddr_wr = '0; cdata_wr = '0; crd = 0; caddr_rd = '0; csel = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({ready, done, timeout, sel_err} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 0000", {ready, done, timeout, sel_err}); end
        n_cmp++; if (wr_cnt !== '0) begin
            n_err++; $display("FAIL reset_wr_cnt: got %0d expected 0", wr_cnt); end
        n_cmp++; if ({t_ready, t_done, t_timeout, t_sel_err} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags_to: got %b expected 0000", {t_ready, t_done, t_timeout, t_sel_err}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_image_load();
        logic [AW-1:0] addrs [4];
        for (int k = 0; k < DEPTH; k++) begin
            load_en = 1'b1; load_addr = k[AW-1:0]; load_data = DW'(k);
            @(negedge clk);
        end
        load_en = 1'b0;
        addrs[0] = 12'h123; addrs[1] = 12'h000; addrs[2] = 12'hFFF; addrs[3] = 12'h800;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(DW'(addrs[i]));
            iaddr = addrs[i];
            #1;
            exp_w = exp_q.pop_front();
            n_cmp++; if (idata !== exp_w) begin
                n_err++; $display("FAIL idata[%h]: got %h expected %h", addrs[i], idata, exp_w); end
        end
        exp_q.push_back(20'h00123);
        dump_sel = 3'b000; dump_addr = 12'h123; iaddr = 12'h123;
        #1;
        exp_w = exp_q.pop_front();
        n_cmp++; if (dump_data !== exp_w) begin
            n_err++; $display("FAIL dump_image: got %h expected %h", dump_data, exp_w); end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_handshake();
        int ready_cycles = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (ready !== 1'b1) begin
            n_err++; $display("FAIL ready_latency: got %b expected 1", ready); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (ready === 1'b1) ready_cycles++;
            if (i == BUSY_DLY) begin busy = 1'b1; busy_rise_cyc = cyc; end
            // Image load attempt while the engine runs must be ignored.
            if (i == 5) begin load_en = 1'b1; load_addr = 12'h123; load_data = 20'hFFFFF; end
            if (i == 6) load_en = 1'b0;
        end
        n_cmp++; if (ready_cycles !== BUSY_DLY + 1) begin
            n_err++; $display("FAIL ready_cycles: got %0d expected %0d", ready_cycles, BUSY_DLY + 1); end
        iaddr = 12'h123;
        #1;
        n_cmp++; if (idata !== 20'h00123) begin
            n_err++; $display("FAIL load_in_run: got %h expected 00123", idata); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_layer_rw();
        @(negedge clk);
        cwr = 1'b1; csel = 3'b011; caddr_wr = 12'h010; cdata_wr = 20'hABCDE;
        exp_wr_cnt++;
        @(negedge clk);
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h010;
        exp_q.push_back(20'hABCDE);
        dump_sel = 3'b011; dump_addr = 12'h010;
        #1;
        exp_w = exp_q.pop_front();
        n_cmp++; if (cdata_rd !== exp_w) begin
            n_err++; $display("FAIL layer_read: got %h expected %h", cdata_rd, exp_w); end
        n_cmp++; if (dump_data !== exp_w) begin
            n_err++; $display("FAIL layer_dump: got %h expected %h", dump_data, exp_w); end
        n_cmp++; if (wr_cnt !== (AW+1)'(exp_wr_cnt)) begin
            n_err++; $display("FAIL wr_cnt_1: got %0d expected %0d", wr_cnt, exp_wr_cnt); end
        crd = 1'b0;
        #1;
        n_cmp++; if (cdata_rd !== '0) begin
            n_err++; $display("FAIL read_idle_zero: got %h expected 00000", cdata_rd); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_same_cycle();
        @(negedge clk);
        cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h0AA; cdata_wr = 20'h22222;
        exp_wr_cnt++;
        @(negedge clk);
        cdata_wr = 20'h11111; crd = 1'b1; caddr_rd = 12'h0AA;
        exp_wr_cnt++;
        exp_q.push_back(20'h22222);
        exp_q.push_back(20'h11111);
        #1;
        exp_w = exp_q.pop_front();
        n_cmp++; if (cdata_rd !== exp_w) begin
            n_err++; $display("FAIL same_cycle_old: got %h expected %h", cdata_rd, exp_w); end
        @(negedge clk);
        cwr = 1'b0;
        #1;
        exp_w = exp_q.pop_front();
        n_cmp++; if (cdata_rd !== exp_w) begin
            n_err++; $display("FAIL same_cycle_new: got %h expected %h", cdata_rd, exp_w); end
        crd = 1'b0;
        n_cmp++; if (wr_cnt !== (AW+1)'(exp_wr_cnt)) begin
            n_err++; $display("FAIL wr_cnt_3: got %0d expected %0d", wr_cnt, exp_wr_cnt); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_sel_err();
        n_cmp++; if (sel_err !== 1'b0) begin
            n_err++; $display("FAIL sel_err_pre: got %b expected 0", sel_err); end
        @(negedge clk);
        cwr = 1'b1; csel = 3'b111; caddr_wr = 12'h010; cdata_wr = 20'h55555;
        crd = 1'b1; caddr_rd = 12'h010;
        #1;
        n_cmp++; if (cdata_rd !== '0) begin
            n_err++; $display("FAIL bad_sel_read: got %h expected 00000", cdata_rd); end
        @(negedge clk);
        cwr = 1'b0; crd = 1'b0;
        n_cmp++; if (sel_err !== 1'b1) begin
            n_err++; $display("FAIL sel_err_set: got %b expected 1", sel_err); end
        n_cmp++; if (wr_cnt !== (AW+1)'(exp_wr_cnt)) begin
            n_err++; $display("FAIL wr_cnt_bad_sel: got %0d expected %0d", wr_cnt, exp_wr_cnt); end
        exp_q.push_back(20'hABCDE);
        dump_sel = 3'b011; dump_addr = 12'h010;
        #1;
        exp_w = exp_q.pop_front();
        n_cmp++; if (dump_data !== exp_w) begin
            n_err++; $display("FAIL bank_untouched: got %h expected %h", dump_data, exp_w); end
        for (int s = 6; s < 8; s++) begin
            dump_sel = s[2:0];
            #1;
            n_cmp++; if (dump_data !== '0) begin
                n_err++; $display("FAIL dump_sel_%0d: got %h expected 00000", s, dump_data); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_run_end();
        while (cyc - busy_rise_cyc < RUN_LEN) @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin
            n_err++; $display("FAIL done_early: got %b expected 0", done); end
        busy = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin
            n_err++; $display("FAIL done_pulse: got %b expected 1", done); end
        @(negedge clk);
        n_cmp++; if ({done, ready} !== 2'b00) begin
            n_err++; $display("FAIL done_single: got %b expected 00", {done, ready}); end
        n_cmp++; if (sel_err !== 1'b1) begin
            n_err++; $display("FAIL sel_err_sticky: got %b expected 1", sel_err); end
        repeat (3) @(negedge clk);
        n_cmp++; if ({done, ready, timeout} !== 3'b000) begin
            n_err++; $display("FAIL idle_after_done: got %b expected 000", {done, ready, timeout}); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout();
        int first_k = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_wr_cnt = 0;
        n_cmp++; if ({t_timeout, sel_err} !== 2'b00) begin
            n_err++; $display("FAIL start_clears: got %b expected 00", {t_timeout, sel_err}); end
        n_cmp++; if (wr_cnt !== '0) begin
            n_err++; $display("FAIL start_clears_cnt: got %0d expected 0", wr_cnt); end
        for (int k = 1; k <= 4 * TO_SMALL; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 2) busy = 1'b1;
            if (t_done === 1'b1) begin first_k = k; break; end
        end
        n_cmp++; if (first_k !== TO_SMALL + 1) begin
            n_err++; $display("FAIL timeout_cycle: got %0d expected %0d", first_k, TO_SMALL + 1); end
        n_cmp++; if (t_timeout !== 1'b1) begin
            n_err++; $display("FAIL timeout_flag: got %b expected 1", t_timeout); end
        @(negedge clk);
        n_cmp++; if ({t_done, t_ready, t_timeout} !== 3'b001) begin
            n_err++; $display("FAIL timeout_after: got %b expected 001", {t_done, t_ready, t_timeout}); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_run();
        // Main instance is still in RUN with busy high.
        cwr = 1'b1; csel = 3'b101; caddr_wr = 12'hFFF; cdata_wr = 20'h7A5A5;
        exp_wr_cnt++;
        @(negedge clk);
        cwr = 1'b0; crd = 1'b1; csel = 3'b000;
        @(negedge clk);
        crd = 1'b0;
        n_cmp++; if ({sel_err, wr_cnt} !== {1'b1, (AW+1)'(exp_wr_cnt)}) begin
            n_err++; $display("FAIL pre_reset: got %b/%0d expected 1/%0d", sel_err, wr_cnt, exp_wr_cnt); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({ready, done, timeout, sel_err, wr_cnt} !== '0) begin
            n_err++; $display("FAIL async_reset: got %b/%0d expected 0000/0", {ready, done, timeout, sel_err}, wr_cnt); end
        n_cmp++; if (t_timeout !== 1'b0) begin
            n_err++; $display("FAIL async_reset_to: got %b expected 0", t_timeout); end
        exp_q.push_back(20'h7A5A5);
        exp_q.push_back(20'h7A5A5);
        dump_sel = 3'b101; dump_addr = 12'hFFF;
        #1;
        exp_w = exp_q.pop_front();
        n_cmp++; if (dump_data !== exp_w) begin
            n_err++; $display("FAIL retained_bank: got %h expected %h", dump_data, exp_w); end
        exp_w = exp_q.pop_front();
        n_cmp++; if (t_dump_data !== exp_w) begin
            n_err++; $display("FAIL retained_bank_to: got %h expected %h", t_dump_data, exp_w); end
        busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_image_load();
        test_handshake();
        test_layer_rw();
        test_same_cycle();
        test_sel_err();
        test_run_end();
        test_timeout();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/conv_mem_host.md
# conv_mem_host

Host-side responder for the convolution engine's memory interface: the block on the other end of `ready`/`busy`, `iaddr`/`idata` and `cwr`/`crd`/`csel`. It holds the input image ROM and the five layer banks, answers the engine's image and layer reads, and captures its layer writes. It runs the `ready`→`busy` handshake and reports completion, timeouts and protocol errors to the system controller. A host load port fills the image and a dump port reads results back.

## Interface
- `AW`, 12, address width of image and every layer bank
- `DW`, 20, data width
- `TIMEOUT`, 32'd2000000, max cycles allowed in ARM+RUN before abort
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  host request to launch one engine run (pulse)
- `load_en`  in  1  host image write strobe
- `load_addr`  in  AW  image write address
- `load_data`  in  DW  image write data
- `dump_sel`  in  3  bank select for host readback (same encoding as `csel`)
- `dump_addr`  in  AW  readback address
- `dump_data`  out  DW  readback data, combinational
- `ready`  out  1  to engine: image valid, start processing
- `busy`  in  1  from engine
- `iaddr`  in  AW  engine image address
- `idata`  out  DW  image word at `iaddr`, combinational
- `cwr`  in  1  engine layer write strobe
- `caddr_wr`  in  AW  layer write address
- `cdata_wr`  in  DW  layer write data
- `crd`  in  1  engine layer read strobe
- `caddr_rd`  in  AW  layer read address
- `cdata_rd`  out  DW  layer read data, combinational
- `csel`  in  3  bank select: 001 L0/k0, 010 L0/k1, 011 L1/k0, 100 L1/k1, 101 L2 flat
- `done`  out  1  one-cycle pulse at end of run
- `timeout`  out  1  sticky: last run aborted by watchdog
- `sel_err`  out  1  sticky: `cwr` or `crd` seen with invalid `csel` (000, 110, 111)
- `wr_cnt`  out  AW+1  number of accepted layer writes in the current/last run

## Operation
- Storage: image ROM plus 5 layer banks, each 2^AW x DW; asynchronous read, synchronous write. Contents are not cleared by reset.
- FSM states IDLE, ARM, RUN, DONE.
  - IDLE: `load_en` writes image[`load_addr`] at the clock edge. `start` moves to ARM and clears `timeout`, `sel_err`, `wr_cnt` and the watchdog.
  - ARM: `ready`=1. When `busy`=1 is sampled, go to RUN; `ready` is 0 from the next cycle.
  - RUN: serve accesses. When `busy`=0 is sampled, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Watchdog: counts every cycle in ARM or RUN. When the count reaches `TIMEOUT`, set `timeout`, drop `ready` and go to DONE (`done` still pulses).
- `load_en` outside IDLE is ignored. `start` outside IDLE is ignored.
- Layer write: `cwr`=1 with a valid `csel` writes bank[`csel`][`caddr_wr`] at the edge and increments `wr_cnt`, saturating at all-ones. Writes are accepted in any state.
- Layer read: `cdata_rd` = bank[`csel`][`caddr_rd`] when `crd`=1 and `csel` is valid, else 0.
- Same-cycle `cwr` and `crd` on one address: `cdata_rd` returns the old word; the new word is visible from the next cycle.
- Invalid `csel` with `cwr` or `crd`: no write, `cdata_rd`=0, `sel_err` set.
- `idata` = image[`iaddr`] at all times, full AW-bit address with no wrap beyond it. Edge padding is the engine's job.
- `dump_data` = bank[`dump_sel`][`dump_addr`]. `dump_sel`=000 returns the image; 110 and 111 return 0.

## Timing
- Reset values: state IDLE, `ready`=0, `done`=0, `timeout`=0, `sel_err`=0, `wr_cnt`=0, watchdog 0.
- `start` sampled at edge N → `ready`=1 from N+1.
- `busy` first sampled high at edge M → `ready`=0 from M+1.
- `busy` sampled low in RUN at edge K → `done`=1 during cycle K+1 only.
- Read latency is 0 cycles (combinational) for `idata`, `cdata_rd` and `dump_data`.
- Reset asserted mid-run: all control outputs return to reset values immediately (asynchronous). Bank data is retained; the engine must be reset together with this block.

## Test plan
- Reset, then load image[k]=k for all 4096 addresses; drive `iaddr`=0x123 → `idata`=0x00123 in the same cycle.
- `start`, engine model raises `busy` 3 cycles later → `ready` high for exactly 4 cycles. Drop `busy` after 100 cycles → single `done` pulse one cycle later, FSM back in IDLE.
- In RUN, `cwr`, `csel`=011, `caddr_wr`=0x010, `cdata_wr`=0xABCDE; next cycle `crd` on the same bank and address → `cdata_rd`=0xABCDE, `wr_cnt`=1. `dump_sel`=011 returns the same word.
- Same-cycle write 0x11111 and read of an address holding 0x22222 → `cdata_rd`=0x22222 that cycle, 0x11111 the next cycle.
- `cwr` with `csel`=111 → no bank changes, `sel_err`=1, `wr_cnt` unchanged. `sel_err` stays set until the next `start`.
- `TIMEOUT`=50, `busy` held high → `timeout`=1 and `done` pulse after 50 cycles in ARM+RUN. Asserting `reset` mid-RUN clears `ready`/`done`/flags immediately while previously written bank data is still readable via dump.
